async_fifo_wr_arbiter: RTL and testbench

- Shares the write port of one async_fifo among NUM_REQ requesters in the wr_clock domain.
- Uses packet-locked round-robin arbitration: a requester keeps the grant until its last beat, or until MAX_BURST beats have been written.
- Drives async_fifo wr_en/data_in directly and throttles on fifo_full/fifo_almost_full, so the FIFO never sees a write while full.

---
 rtl/async_fifo_wr_arbiter.sv | 115 +++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing one async_fifo write port among
// NUM_REQ requesters; a grant lasts until req_last or MAX_BURST beats.
module async_fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                          wr_clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic [NUM_REQ-1:0]            grant,
  output logic [7:0]                    beat_cnt,
  output logic                          burst_trunc
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_next;
  logic [PTR_W-1:0]   owner, owner_next;
  logic [PTR_W-1:0]   winner;
  logic               found;
  logic [NUM_REQ-1:0] grant_next;
  logic [7:0]         beat_cnt_next;
  logic               burst_trunc_next;

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx[PTR_W-1:0];
      end
    end
  end

  // Handshakes are suppressed while reset is held so an aborted packet adds no beat.
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_data_in = '0;
    if (state == BUSY) begin
      fifo_data_in = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
      if (reset && !fifo_full) req_ready[owner] = 1'b1;
      fifo_wr_en = req_valid[owner] & req_ready[owner];
    end
  end

  always_comb begin
    state_next       = state;
    grant_next       = grant;
    rr_ptr_next      = rr_ptr;
    owner_next       = owner;
    beat_cnt_next    = beat_cnt;
    burst_trunc_next = 1'b0;
    case (state)
      IDLE: begin
        if (found && !fifo_almost_full) begin
          state_next    = BUSY;
          grant_next    = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
          owner_next    = winner;
          beat_cnt_next = 8'd0;
        end
      end
      BUSY: begin
        if (fifo_wr_en) begin
          if (req_last[owner] || beat_cnt == LAST_BEAT) begin
            state_next       = IDLE;
            grant_next       = '0;
            beat_cnt_next    = 8'd0;
            rr_ptr_next      = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            burst_trunc_next = ~req_last[owner];
          end else begin
            beat_cnt_next = beat_cnt + 8'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wr_clock) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      owner       <= '0;
      beat_cnt    <= 8'd0;
      burst_trunc <= 1'b0;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      rr_ptr      <= rr_ptr_next;
      owner       <= owner_next;
      beat_cnt    <= beat_cnt_next;
      burst_trunc <= burst_trunc_next;
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Bench for async_fifo_wr_arbiter: cycle table of directed vectors, then
// packet sequences against a requester/FIFO model (depth 8).
module tb_async_fifo_wr_arbiter;

  localparam int DW = 32, NREQ = 4, MAXB = 8, DEPTH = 8;

  logic wr_clock = 1'b0;
  always #5 wr_clock = ~wr_clock;

  logic                 reset;
  logic [NREQ-1:0]      req_valid, req_last, req_ready, grant;
  logic [NREQ*DW-1:0]   req_data;
  logic                 fifo_wr_en, fifo_full, fifo_almost_full, burst_trunc;
  logic [DW-1:0]        fifo_data_in;
  logic [7:0]           beat_cnt;

  async_fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NREQ), .MAX_BURST(MAXB)) dut (
    .wr_clock(wr_clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in), .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
    .grant(grant), .beat_cnt(beat_cnt), .burst_trunc(burst_trunc)
  );

  typedef struct {
    logic [3:0] valid, last;
    logic       full, af;
    logic [3:0] exp_grant, exp_ready;
    logic       exp_wr;
    logic [7:0] exp_cnt;
    logic       exp_trunc;
  } vec_t;

  vec_t vq[$];

  int checks = 0, failures = 0;
  int overflow = 0, onehot_viol = 0, full_wr_viol = 0, full_cycles = 0;
  bit src_mode;
  logic tv_reset, tv_full, tv_af, rd_en;
  logic [NREQ-1:0] tv_valid, tv_last;
  logic [32:0] src_q [NREQ][$];
  logic [DW-1:0] fifo_q[$], wr_log[$], rd_log[$];
  logic s_wr;
  logic [DW-1:0] s_data;
  logic [NREQ-1:0] s_hs;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [3:0] v, l, input logic f, a, input logic [3:0] g, r,
                        input logic w, input logic [7:0] c, input logic t);
    vec_t x;
    x.valid = v; x.last = l; x.full = f; x.af = a;
    x.exp_grant = g; x.exp_ready = r; x.exp_wr = w; x.exp_cnt = c; x.exp_trunc = t;
    vq.push_back(x);
  endtask

  task automatic loadPacket(input int r, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) src_q[r].push_back({(k == n - 1) ? 1'b1 : 1'b0, base + 32'(k)});
  endtask

  function automatic logic [DW-1:0] tableData(input logic [3:0] g);
    for (int i = 0; i < NREQ; i++) if (g[i]) return 32'hD0 + 32'(i);
    return '0;
  endfunction

  // Drive on the falling edge, then sample the settled outputs 1 ns later.
  task automatic applyStimulus();
    @(negedge wr_clock);
    reset = tv_reset;
    if (src_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = src_q[i][0][DW-1:0];
          req_last[i] = src_q[i][0][DW];
        end else begin
          req_valid[i] = 1'b0;
          req_data[i*DW +: DW] = '0;
          req_last[i] = 1'b0;
        end
      end
      fifo_full        = (fifo_q.size() >= DEPTH) ? 1'b1 : 1'b0;
      fifo_almost_full = (fifo_q.size() >= DEPTH - 1) ? 1'b1 : 1'b0;
    end else begin
      req_valid = tv_valid;
      req_last  = tv_last;
      for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 32'hD0 + 32'(i);
      fifo_full        = tv_full;
      fifo_almost_full = tv_af;
    end
    #1;
    s_wr   = fifo_wr_en;
    s_data = fifo_data_in;
    s_hs   = req_valid & req_ready;
    if ($countones(req_ready) > 1) onehot_viol++;
    if (fifo_full && fifo_wr_en) full_wr_viol++;
    if (fifo_full) full_cycles++;
  endtask

  task automatic clockEdge();
    int pre;
    logic [32:0] d33;
    logic [DW-1:0] d;
    @(posedge wr_clock);
    pre = fifo_q.size();
    if (rd_en && pre > 0) begin
      d = fifo_q.pop_front();
      rd_log.push_back(d);
    end
    if (s_wr) begin
      wr_log.push_back(s_data);
      if (pre >= DEPTH) overflow++;
      else fifo_q.push_back(s_data);
    end
    if (src_mode)
      for (int i = 0; i < NREQ; i++)
        if (s_hs[i] && src_q[i].size() > 0) d33 = src_q[i].pop_front();
  endtask

  task automatic tick();
    applyStimulus();
    clockEdge();
  endtask

  initial begin
    int cycles, maxcnt, pulses, trunc_writes;
    logic [31:0] bases [5];
    reset = 1'b0; tv_reset = 1'b0; src_mode = 1'b0; rd_en = 1'b0;
    tv_valid = 4'b1111; tv_last = 4'b1111; tv_full = 1'b0; tv_af = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0; fifo_almost_full = 1'b0;

    // Table rows: valid, last, full, af | grant, ready, wr_en, beat_cnt, trunc
    addVec(4'b1111, 4'b1111, 0, 0, 4'b0001, 4'b0001, 1, 8'd0, 0);
    addVec(4'b1111, 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 8'd0, 0);
    addVec(4'b1111, 4'b1111, 0, 0, 4'b0010, 4'b0010, 1, 8'd0, 0);
    addVec(4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 8'd0, 0);
    addVec(4'b0001, 4'b0000, 1, 0, 4'b0001, 4'b0000, 0, 8'd0, 0);
    addVec(4'b0001, 4'b0000, 0, 0, 4'b0001, 4'b0001, 1, 8'd0, 0);
    addVec(4'b0000, 4'b0000, 0, 0, 4'b0001, 4'b0001, 0, 8'd1, 0);
    addVec(4'b0001, 4'b0001, 0, 1, 4'b0001, 4'b0001, 1, 8'd1, 0);
    addVec(4'b0100, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 8'd0, 0);
    addVec(4'b0100, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 8'd0, 0);
    addVec(4'b0100, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 8'd0, 0);
    addVec(4'b0100, 4'b0000, 0, 1, 4'b0100, 4'b0100, 1, 8'd0, 0);
    addVec(4'b0100, 4'b0100, 0, 1, 4'b0100, 4'b0100, 1, 8'd1, 0);
    addVec(4'b1010, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 8'd0, 0);
    addVec(4'b1010, 4'b1000, 0, 0, 4'b1000, 4'b1000, 1, 8'd0, 0);
    addVec(4'b1010, 4'b1010, 0, 0, 4'b0000, 4'b0000, 0, 8'd0, 0);
    addVec(4'b0010, 4'b0010, 0, 0, 4'b0010, 4'b0010, 1, 8'd0, 0);
    addVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 8'd0, 0);

    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      checkOutput("reset_req_ready", 64'(req_ready), 0);
      checkOutput("reset_wr_en", 64'(fifo_wr_en), 0);
      checkOutput("reset_grant", 64'(grant), 0);
      clockEdge();
    end
    tv_reset = 1'b1;
    applyStimulus();
    checkOutput("release_grant", 64'(grant), 0);
    checkOutput("release_beat_cnt", 64'(beat_cnt), 0);
    checkOutput("release_trunc", 64'(burst_trunc), 0);
    clockEdge();

    foreach (vq[n]) begin
      tv_valid = vq[n].valid; tv_last = vq[n].last; tv_full = vq[n].full; tv_af = vq[n].af;
      applyStimulus();
      checkOutput($sformatf("vec%0d_grant", n), 64'(grant), 64'(vq[n].exp_grant));
      checkOutput($sformatf("vec%0d_ready", n), 64'(req_ready), 64'(vq[n].exp_ready));
      checkOutput($sformatf("vec%0d_wr_en", n), 64'(fifo_wr_en), 64'(vq[n].exp_wr));
      checkOutput($sformatf("vec%0d_data", n), 64'(fifo_data_in), 64'(tableData(vq[n].exp_grant)));
      checkOutput($sformatf("vec%0d_beat_cnt", n), 64'(beat_cnt), 64'(vq[n].exp_cnt));
      checkOutput($sformatf("vec%0d_trunc", n), 64'(burst_trunc), 64'(vq[n].exp_trunc));
      clockEdge();
    end

    // Round robin over 2-beat packets with the FIFO being read every cycle.
    src_mode = 1'b1; tv_reset = 1'b0;
    tick();
    tv_reset = 1'b1; rd_en = 1'b1;
    wr_log.delete(); fifo_q.delete();
    loadPacket(0, 32'hA0, 2); loadPacket(0, 32'hE0, 2);
    loadPacket(1, 32'hB0, 2); loadPacket(2, 32'hC0, 2); loadPacket(3, 32'hD0, 2);
    bases = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hE0};
    cycles = 0;
    while (wr_log.size() < 10 && cycles < 40) begin tick(); cycles++; end
    checkOutput("rr_write_count", 64'(wr_log.size()), 10);
    checkOutput("rr_cycles", 64'(cycles), 15);
    for (int k = 0; k < 10 && k < wr_log.size(); k++)
      checkOutput($sformatf("rr_data%0d", k), 64'(wr_log[k]), 64'(bases[k/2] + 32'(k % 2)));

    // Burst truncation: 10-beat packet from requester 2 alone.
    wr_log.delete();
    loadPacket(2, 32'h200, 10);
    maxcnt = 0; pulses = 0; trunc_writes = -1; cycles = 0;
    while (wr_log.size() < 10 && cycles < 60) begin
      applyStimulus();
      if (int'(beat_cnt) > maxcnt) maxcnt = int'(beat_cnt);
      if (burst_trunc) begin pulses++; trunc_writes = wr_log.size(); end
      clockEdge();
      cycles++;
    end
    applyStimulus();
    checkOutput("trunc_none_after_last", 64'(burst_trunc), 0);
    checkOutput("trunc_grant_released", 64'(grant), 0);
    clockEdge();
    checkOutput("trunc_write_count", 64'(wr_log.size()), 10);
    checkOutput("trunc_max_beat_cnt", 64'(maxcnt), 7);
    checkOutput("trunc_pulses", 64'(pulses), 1);
    checkOutput("trunc_after_writes", 64'(trunc_writes), 8);
    for (int k = 0; k < 10 && k < wr_log.size(); k++)
      checkOutput($sformatf("trunc_data%0d", k), 64'(wr_log[k]), 64'(32'h200 + 32'(k)));

    // Backpressure: 12 beats into a depth-8 FIFO with reads held off.
    rd_en = 1'b0; wr_log.delete(); rd_log.delete(); fifo_q.delete();
    full_wr_viol = 0; full_cycles = 0; overflow = 0;
    loadPacket(0, 32'h300, 12);
    for (int c = 0; c < 20; c++) tick();
    checkOutput("bp_writes_while_blocked", 64'(wr_log.size()), 8);
    checkOutput("bp_fifo_level", 64'(fifo_q.size()), 8);
    checkOutput("bp_full_seen", 64'(full_cycles > 0), 1);
    rd_en = 1'b1; cycles = 0;
    while ((wr_log.size() < 12 || fifo_q.size() > 0) && cycles < 80) begin tick(); cycles++; end
    checkOutput("bp_total_writes", 64'(wr_log.size()), 12);
    checkOutput("bp_total_reads", 64'(rd_log.size()), 12);
    checkOutput("bp_wr_while_full", 64'(full_wr_viol), 0);
    checkOutput("bp_overflow", 64'(overflow), 0);
    for (int k = 0; k < 12 && k < rd_log.size(); k++)
      checkOutput($sformatf("bp_read%0d", k), 64'(rd_log[k]), 64'(32'h300 + 32'(k)));

    // Reset after beat 3 of a 5-beat packet from requester 1.
    rd_en = 1'b0; wr_log.delete(); fifo_q.delete();
    loadPacket(1, 32'h400, 5);
    cycles = 0;
    while (wr_log.size() < 3 && cycles < 20) begin tick(); cycles++; end
    tv_reset = 1'b0;
    applyStimulus();
    checkOutput("abort_wr_en", 64'(fifo_wr_en), 0);
    checkOutput("abort_req_ready", 64'(req_ready), 0);
    clockEdge();
    tv_reset = 1'b1;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    loadPacket(0, 32'h500, 1);
    loadPacket(3, 32'h503, 1);
    applyStimulus();
    checkOutput("abort_grant", 64'(grant), 0);
    checkOutput("abort_fifo_level", 64'(fifo_q.size()), 3);
    clockEdge();
    applyStimulus();
    checkOutput("abort_rr_restart_grant", 64'(grant), 64'(4'b0001));
    clockEdge();
    checkOutput("ready_onehot", 64'(onehot_viol), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
